ccp_wr_data_sequencer: RTL and testbench
========================================

Name: ccp_wr_data_sequencer

Overview:
- Controller-side write-data sequencer, directly upstream of the CCP cache write port.
- Each op the tag pipe accepts at p2 with write_data or bypass set is recorded in a command FIFO. The block then pulls the matching data beats from the controller data buffer and drives the ctrl_wr_* channel with a valid/ready handshake.
- It generates beat_num (critical-beat-first, wrapping), ctrl_wr_last and forced full byte enables, so the cache write-port protocol holds by construction.

Parameters:
- DATA_W, 129, write beat width (includes 1 poison bit).
- BYTE_EN_W, 16, byte enables per beat.
- BURST_LEN_W, 2, beat-count field width; BURST_LEN = 2**BURST_LEN_W.
- CMD_DEPTH, 4, command FIFO entries (power of 2, at least 2).
- CNT_W, $clog2(CMD_DEPTH)+1, occupancy width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- op_push_p2  in  1  op accepted at p2 (valid, no nack) and needing write data (write_data or bypass).
- op_bypass_only_p2  in  1  bypass without cache write.
- op_full_p2  in  1  allocate with valid-state tag update: full-line write.
- op_burst_len_p2  in  BURST_LEN_W  number of beats minus 1.
- op_start_beat_p2  in  BURST_LEN_W  first beat index (address beat offset).
- src_valid  in  1  data buffer beat available.
- src_data  in  DATA_W  beat data.
- src_byte_en  in  BYTE_EN_W  beat byte enables.
- src_ready  out  1  beat consumed this cycle.
- ctrl_wr_valid  out  1  write beat valid to cache.
- ctrl_wr_data  out  DATA_W  beat data.
- ctrl_wr_byte_en  out  BYTE_EN_W  byte enables.
- ctrl_wr_beat_num  out  BURST_LEN_W  beat index.
- ctrl_wr_last  out  1  final beat of the op.
- cache_wr_ready  in  1  cache accepts the beat.
- cmd_full  out  1  FIFO full; upstream must not push.
- cmd_count  out  CNT_W  FIFO occupancy.
- overflow_err  out  1  sticky error: push while full.

Behaviour:
- Reset, synchronous: all outputs 0, FIFO empty, beat counter 0, overflow_err cleared. Any partial burst or queued command is discarded.
- Command FIFO:
  - Entry fields are {bypass_only, full, burst_len, start_beat}.
  - A push writes the tail at the clock edge. The entry is visible at the head from the next cycle; there is no same-cycle bypass.
  - Push while full and no pop in the same cycle: the entry is dropped and overflow_err is set until reset. Push while full with a same-cycle pop is legal.
  - cmd_full = (cmd_count == CMD_DEPTH). cmd_count is updated +1, -1, or 0 for simultaneous push and pop.
- Output register:
  - Single stage; all ctrl_wr_* fields are registered.
  - load = head_valid && src_valid && (!ctrl_wr_valid || cache_wr_ready).
  - src_ready = load.
  - While ctrl_wr_valid && !cache_wr_ready, every ctrl_wr_* field holds its value.
  - Without load, a cache_wr_ready acceptance clears ctrl_wr_valid the next cycle.
- Per-beat generation on load:
  - ctrl_wr_beat_num = (start_beat + beat_cnt) mod BURST_LEN, i.e. wrapping.
  - ctrl_wr_last = (beat_cnt == burst_len).
  - ctrl_wr_byte_en = all ones if full, else src_byte_en.
  - ctrl_wr_data = src_data.
  - beat_cnt increments on each load and resets to 0 on a load with last set. No beat index repeats within an op.
- Command pop: the head is popped on the load of its last beat. The next op's first beat can load the following cycle, giving back-to-back beats across ops.
- Latency: a push in cycle N with src_valid held gives ctrl_wr_valid in cycle N+2 at the earliest.
- Throughput: 1 beat/cycle while cache_wr_ready=1.
- Protocol invariants:
  - ctrl_wr_valid=0 whenever the FIFO is empty and no beat is pending.
  - An op_full_p2 push must carry burst_len = BURST_LEN-1. This is an input requirement, flagged by an internal assertion.

Test Plan:
- Push {full=1, burst_len=3, start=2}, src_valid constant, cache_wr_ready=1 -> beat_num 2,3,0,1; byte_en=16'hFFFF on every beat; last only on beat_num 1; ctrl_wr_valid first seen at cycle N+2.
- Push {full=0, burst_len=0, start=1}, src_byte_en=16'h00F0, cache_wr_ready=0 for 3 cycles -> valid, data, byte_en=16'h00F0, beat_num=1 and last=1 all held 3 cycles; src_ready=0 during the stall; accepted in cycle 4.
- Two ops back-to-back (burst_len=1 then burst_len=0) -> 3 consecutive valid beats with no bubble; last on beats 2 and 3; cmd_count goes 2->1->0.
- Push 4 ops with src_valid=0, then push a 5th -> cmd_full=1, overflow_err=1 sticky, cmd_count=4; 4 bursts drain afterwards.
- Push while full in the same cycle as a pop (last beat loaded) -> no overflow_err; cmd_count stays 4.
- Assert reset mid-burst after beat 1 of 4 -> all outputs 0 next cycle and cmd_count=0; a new op afterwards starts at its start_beat with beat_cnt=0.

Source files
------------

// File: rtl/ccp_wr_data_sequencer.sv
// Write-data sequencer: queues write ops, pulls data-buffer beats, drives the cache write channel.
// Latency: push to first ctrl_wr_valid is 2 cycles minimum; 1 beat/cycle sustained.
// Backpressure: cache_wr_ready low freezes the output register and holds src_ready low.
module ccp_wr_data_sequencer #(
    parameter int DATA_W      = 129,
    parameter int BYTE_EN_W   = 16,
    parameter int BURST_LEN_W = 2,
    parameter int CMD_DEPTH   = 4,
    parameter int CNT_W       = $clog2(CMD_DEPTH) + 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   op_push_p2,
    input  logic                   op_bypass_only_p2,
    input  logic                   op_full_p2,
    input  logic [BURST_LEN_W-1:0] op_burst_len_p2,
    input  logic [BURST_LEN_W-1:0] op_start_beat_p2,
    input  logic                   src_valid,
    input  logic [DATA_W-1:0]      src_data,
    input  logic [BYTE_EN_W-1:0]   src_byte_en,
    output logic                   src_ready,
    output logic                   ctrl_wr_valid,
    output logic [DATA_W-1:0]      ctrl_wr_data,
    output logic [BYTE_EN_W-1:0]   ctrl_wr_byte_en,
    output logic [BURST_LEN_W-1:0] ctrl_wr_beat_num,
    output logic                   ctrl_wr_last,
    input  logic                   cache_wr_ready,
    output logic                   cmd_full,
    output logic [CNT_W-1:0]       cmd_count,
    output logic                   overflow_err
);

    localparam int PTR_W = $clog2(CMD_DEPTH);

    typedef struct packed {
        logic                   bypass_only;
        logic                   full;
        logic [BURST_LEN_W-1:0] burst_len;
        logic [BURST_LEN_W-1:0] start_beat;
    } cmd_t;

    cmd_t                   cmd_mem_q [CMD_DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [BURST_LEN_W-1:0] beat_cnt_q, beat_cnt_d;
    logic                   overflow_q;

    logic                   vld_q;
    logic [DATA_W-1:0]      dat_q;
    logic [BYTE_EN_W-1:0]   be_q;
    logic [BURST_LEN_W-1:0] beat_num_q;
    logic                   last_q;

    cmd_t head;
    cmd_t push_cmd;
    logic head_valid;
    logic head_last;
    logic fifo_full;
    logic load;
    logic pop;
    logic push_ok;
    logic push_drop;

    // Head decode, load/pop/push qualification and pointer/counter next state.
    always_comb begin
        head       = cmd_mem_q[rd_ptr_q];
        head_valid = (count_q != '0);
        fifo_full  = (count_q == CNT_W'(CMD_DEPTH));
        head_last  = (beat_cnt_q == head.burst_len);
        load       = head_valid && src_valid && (!vld_q || cache_wr_ready);
        pop        = load && head_last;
        // A full FIFO still accepts a push when its head retires in the same cycle.
        push_ok    = op_push_p2 && (!fifo_full || pop);
        push_drop  = op_push_p2 && fifo_full && !pop;

        push_cmd             = '0;
        push_cmd.bypass_only = op_bypass_only_p2;
        push_cmd.full        = op_full_p2;
        push_cmd.burst_len   = op_burst_len_p2;
        push_cmd.start_beat  = op_start_beat_p2;

        wr_ptr_d   = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d    = count_q;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        beat_cnt_d = beat_cnt_q;
        if (load) begin
            beat_cnt_d = head_last ? '0 : beat_cnt_q + 1'b1;
        end
    end

    // Command storage; contents need no reset because occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            cmd_mem_q[wr_ptr_q] <= push_cmd;
        end
    end

    // FIFO bookkeeping, beat counter and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            beat_cnt_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            beat_cnt_q <= beat_cnt_d;
            if (push_drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Output register: load a new beat, hold while stalled, drop valid once accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q      <= 1'b0;
            dat_q      <= '0;
            be_q       <= '0;
            beat_num_q <= '0;
            last_q     <= 1'b0;
        end else if (load) begin
            vld_q      <= 1'b1;
            dat_q      <= src_data;
            be_q       <= head.full ? {BYTE_EN_W{1'b1}} : src_byte_en;
            beat_num_q <= head.start_beat + beat_cnt_q;
            last_q     <= head_last;
        end else if (cache_wr_ready) begin
            vld_q      <= 1'b0;
        end
    end

    assign src_ready        = load;
    assign ctrl_wr_valid    = vld_q;
    assign ctrl_wr_data     = dat_q;
    assign ctrl_wr_byte_en  = be_q;
    assign ctrl_wr_beat_num = beat_num_q;
    assign ctrl_wr_last     = last_q;
    assign cmd_full         = fifo_full;
    assign cmd_count        = count_q;
    assign overflow_err     = overflow_q;

    // Full-line allocations must cover the whole line.
    a_full_len: assert property (@(posedge clk) disable iff (reset)
        (op_push_p2 && op_full_p2) |-> (op_burst_len_p2 == {BURST_LEN_W{1'b1}}));

    // A bypass-only op never writes the cache, so it can never be a full-line allocation.
    a_bypass_no_alloc: assert property (@(posedge clk) disable iff (reset)
        head_valid |-> !(head.bypass_only && head.full));

endmodule

// File: tb/tb_ccp_wr_data_sequencer.sv
module tb_ccp_wr_data_sequencer;
    localparam int DATA_W      = 129;
    localparam int BYTE_EN_W   = 16;
    localparam int BURST_LEN_W = 2;
    localparam int CMD_DEPTH   = 4;
    localparam int CNT_W       = 3;

    logic                   clk;
    logic                   reset;
    logic                   op_push_p2;
    logic                   op_bypass_only_p2;
    logic                   op_full_p2;
    logic [BURST_LEN_W-1:0] op_burst_len_p2;
    logic [BURST_LEN_W-1:0] op_start_beat_p2;
    logic                   src_valid;
    logic [DATA_W-1:0]      src_data;
    logic [BYTE_EN_W-1:0]   src_byte_en;
    logic                   src_ready;
    logic                   ctrl_wr_valid;
    logic [DATA_W-1:0]      ctrl_wr_data;
    logic [BYTE_EN_W-1:0]   ctrl_wr_byte_en;
    logic [BURST_LEN_W-1:0] ctrl_wr_beat_num;
    logic                   ctrl_wr_last;
    logic                   cache_wr_ready;
    logic                   cmd_full;
    logic [CNT_W-1:0]       cmd_count;
    logic                   overflow_err;

    ccp_wr_data_sequencer #(
        .DATA_W(DATA_W), .BYTE_EN_W(BYTE_EN_W), .BURST_LEN_W(BURST_LEN_W),
        .CMD_DEPTH(CMD_DEPTH), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset),
        .op_push_p2(op_push_p2), .op_bypass_only_p2(op_bypass_only_p2),
        .op_full_p2(op_full_p2), .op_burst_len_p2(op_burst_len_p2),
        .op_start_beat_p2(op_start_beat_p2),
        .src_valid(src_valid), .src_data(src_data), .src_byte_en(src_byte_en),
        .src_ready(src_ready),
        .ctrl_wr_valid(ctrl_wr_valid), .ctrl_wr_data(ctrl_wr_data),
        .ctrl_wr_byte_en(ctrl_wr_byte_en), .ctrl_wr_beat_num(ctrl_wr_beat_num),
        .ctrl_wr_last(ctrl_wr_last), .cache_wr_ready(cache_wr_ready),
        .cmd_full(cmd_full), .cmd_count(cmd_count), .overflow_err(overflow_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: queue of accepted ops, position inside the head op,
    // and the beat that should currently be presented to the cache.
    typedef struct {
        bit bo;
        bit full;
        int len;
        int st;
    } cmd_t;

    cmd_t              cmdq[$];
    int                beat_i;
    bit                ovf_m;
    bit                e_vld;
    logic [DATA_W-1:0] e_dat;
    logic [15:0]       e_be;
    logic [1:0]        e_bn;
    bit                e_last;

    int n_cmp;
    int n_bad;

    task automatic check_eq(input string tag, input logic [159:0] act, input logic [159:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, check registered state and src_ready, advance model.
    task automatic step(input bit push, input bit full, input int len, input int st,
                        input bit sv, input bit rdy);
        bit   ld;
        cmd_t h;
        cmd_t c;
        @(posedge clk);
        #1;
        op_push_p2        = push;
        op_bypass_only_p2 = push && !full && ($urandom_range(0, 3) == 0);
        op_full_p2        = push && full;
        op_burst_len_p2   = len[1:0];
        op_start_beat_p2  = st[1:0];
        src_valid         = sv;
        src_data          = {$urandom(), $urandom(), $urandom(), $urandom(), 1'($urandom())};
        src_byte_en       = 16'($urandom());
        cache_wr_ready    = rdy;
        @(negedge clk);
        check_eq("wr_vld", ctrl_wr_valid, e_vld);
        if (e_vld) begin
            check_eq("wr_data", ctrl_wr_data, e_dat);
            check_eq("wr_byte_en", ctrl_wr_byte_en, e_be);
            check_eq("wr_beat_num", ctrl_wr_beat_num, e_bn);
            check_eq("wr_last", ctrl_wr_last, e_last);
        end
        check_eq("cmd_count", cmd_count, cmdq.size());
        check_eq("cmd_full", cmd_full, cmdq.size() == CMD_DEPTH);
        check_eq("overflow_err", overflow_err, ovf_m);
        ld = (cmdq.size() > 0) && sv && (!e_vld || rdy);
        check_eq("src_ready", src_ready, ld);
        if (ld) begin
            h      = cmdq[0];
            e_vld  = 1'b1;
            e_dat  = src_data;
            e_be   = h.full ? 16'hFFFF : src_byte_en;
            e_bn   = 2'((h.st + beat_i) % 4);
            e_last = (beat_i == h.len);
            if (e_last) begin
                void'(cmdq.pop_front());
                beat_i = 0;
            end else begin
                beat_i++;
            end
        end else if (rdy) begin
            e_vld = 1'b0;
        end
        if (push) begin
            if (cmdq.size() < CMD_DEPTH) begin
                c.bo   = op_bypass_only_p2;
                c.full = full;
                c.len  = len;
                c.st   = st;
                cmdq.push_back(c);
            end else begin
                ovf_m = 1'b1;
            end
        end
    endtask

    task automatic idle(input int n, input bit sv, input bit rdy);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 0, sv, rdy);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset          = 1'b1;
        op_push_p2     = 1'b0;
        src_valid      = 1'b0;
        cache_wr_ready = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        cmdq.delete();
        beat_i = 0;
        ovf_m  = 1'b0;
        e_vld  = 1'b0;
        @(negedge clk);
        check_eq("rst_vld", ctrl_wr_valid, 1'b0);
        check_eq("rst_data", ctrl_wr_data, 0);
        check_eq("rst_byte_en", ctrl_wr_byte_en, 0);
        check_eq("rst_beat_num", ctrl_wr_beat_num, 0);
        check_eq("rst_last", ctrl_wr_last, 1'b0);
        check_eq("rst_count", cmd_count, 0);
        check_eq("rst_full", cmd_full, 1'b0);
        check_eq("rst_overflow", overflow_err, 1'b0);
        check_eq("rst_src_ready", src_ready, 1'b0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit push;
        bit full;
        int len;
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b1;
        op_push_p2 = 1'b0; op_bypass_only_p2 = 1'b0; op_full_p2 = 1'b0;
        op_burst_len_p2 = '0; op_start_beat_p2 = '0;
        src_valid = 1'b0; src_data = '0; src_byte_en = '0; cache_wr_ready = 1'b0;
        beat_i = 0; ovf_m = 1'b0; e_vld = 1'b0;
        e_dat = '0; e_be = '0; e_bn = '0; e_last = 1'b0;

        // Full-line op with wrapping critical-beat-first order.
        do_reset();
        step(1'b1, 1'b1, 3, 2, 1'b1, 1'b1);
        idle(7, 1'b1, 1'b1);

        // Single partial beat held through a 3-cycle stall.
        step(1'b1, 1'b0, 0, 1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 0, 0, 1'b1, 1'b0);
        idle(3, 1'b1, 1'b0);
        idle(3, 1'b0, 1'b1);

        // Back-to-back ops with no bubble between them.
        step(1'b1, 1'b0, 1, 0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 0, 3, 1'b0, 1'b1);
        idle(6, 1'b1, 1'b1);

        // Fill, overflow on a fifth push, then drain.
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, i, 3 - i, 1'b0, 1'b1);
        step(1'b1, 1'b0, 2, 2, 1'b0, 1'b1);
        idle(2, 1'b0, 1'b1);
        idle(16, 1'b1, 1'b1);

        // Push into a full FIFO in the same cycle its head retires.
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 0, i, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1, 2, 1'b1, 1'b1);
        idle(10, 1'b1, 1'b1);

        // Reset mid-burst, then a fresh op starts at its own start beat.
        step(1'b1, 1'b0, 3, 1, 1'b0, 1'b1);
        idle(2, 1'b1, 1'b1);
        do_reset();
        step(1'b1, 1'b0, 3, 2, 1'b1, 1'b1);
        idle(7, 1'b1, 1'b1);

        // Randomized traffic with random stalls and occasional reset.
        for (int n = 0; n < 4000; n++) begin
            if (n % 700 == 699) do_reset();
            push = ($urandom_range(0, 2) == 0) &&
                   (cmdq.size() < CMD_DEPTH || $urandom_range(0, 19) == 0);
            full = ($urandom_range(0, 3) == 0);
            len  = full ? 3 : int'($urandom_range(0, 3));
            step(push, full, len, int'($urandom_range(0, 3)),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
        end
        idle(20, 1'b1, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
